ftm_buffer_writer: RTL and testbench



---
 rtl/ftm_buffer_writer_pkg.sv | 30 +++
 rtl/ftm_shape_decode.sv | 21 ++
 rtl/ftm_buffer_writer.sv | 173 +++++++++++++++++
 tb/tb_ftm_buffer_writer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ftm_buffer_writer_pkg.sv
// Definitions shared by the feature-map buffer writer and the strided reader:
// shape word layout, counter widths, FSM states and the channel-wrap helper.
package ftm_buffer_writer_pkg;

   localparam int SHAPE_C_MSB = 31;
   localparam int SHAPE_C_LSB = 20;
   localparam int SHAPE_H_MSB = 19;
   localparam int SHAPE_H_LSB = 10;
   localparam int SHAPE_W_MSB = 9;
   localparam int SHAPE_W_LSB = 0;

   localparam int C_W  = SHAPE_C_MSB - SHAPE_C_LSB + 1;
   localparam int DC_W = 7;
   localparam int Y_W  = 10;
   localparam int X_W  = 10;
   localparam int CW_W = 20;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STREAM = 2'd2
   } ftm_state_e;

   // Channel words per pixel: each buffer word carries 4*N_CONV_UNIT channels.
   function automatic logic [DC_W-1:0] calc_n_wrap_c(input logic [C_W-1:0] c,
                                                      input int unsigned shift);
      return DC_W'(c >> shift);
   endfunction

endpackage

// File: rtl/ftm_shape_decode.sv
// Splits a packed feature-map shape word into height, width and the
// channel wrap count; shared with the strided reader.
module ftm_shape_decode
   import ftm_buffer_writer_pkg::*;
#(
   parameter int B_SHAPE     = 32,
   parameter int N_CONV_UNIT = 8
) (
   input  logic [B_SHAPE-1:0] shape_i,
   output logic [Y_W-1:0]     h_o,
   output logic [X_W-1:0]     w_o,
   output logic [DC_W-1:0]    n_wrap_c_o
);

   localparam int unsigned NW_SHIFT = $clog2(4 * N_CONV_UNIT);

   assign h_o        = shape_i[SHAPE_H_MSB:SHAPE_H_LSB];
   assign w_o        = shape_i[SHAPE_W_MSB:SHAPE_W_LSB];
   assign n_wrap_c_o = calc_n_wrap_c(shape_i[SHAPE_C_MSB:SHAPE_C_LSB], NW_SHIFT);

endmodule

// File: rtl/ftm_buffer_writer.sv
// Scatters a streamed feature map column-interleaved across N_BUF_X buffer
// banks in the layout the strided reader expects; toggles tog per finished map.
module ftm_buffer_writer
   import ftm_buffer_writer_pkg::*;
#(
   parameter int N_BUF_X     = 10,
   parameter int B_BUF_ADDR  = 9,
   parameter int B_SHAPE     = 32,
   parameter int DATA_WIDTH  = 64,
   parameter int N_CONV_UNIT = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [B_SHAPE-1:0]    ftm_shape,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [N_BUF_X-1:0]    wr_en,
   output logic [B_BUF_ADDR-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  shape_err,
   output logic                  last_err,
   output logic                  tog
);

   localparam int XR_W   = $clog2(N_BUF_X);
   localparam int NC_W   = X_W + 1;
   localparam int NEED_W = CW_W + NC_W;
   localparam logic [NEED_W-1:0] DEPTH = NEED_W'(1) << B_BUF_ADDR;

   ftm_state_e              state_q;
   logic [B_SHAPE-1:0]      shape_q;
   logic [B_BUF_ADDR-1:0]   col_words_q;
   logic [DC_W-1:0]         dc_q;
   logic [Y_W-1:0]          y_q;
   logic [X_W-1:0]          x_q;
   logic [XR_W-1:0]         x_rem_q;
   logic [B_BUF_ADDR-1:0]   addr_q, col_base_q;
   logic [N_BUF_X-1:0]      wr_en_q;
   logic [B_BUF_ADDR-1:0]   wr_addr_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;
   logic                    shape_err_q, last_err_q, tog_q;

   logic [Y_W-1:0]          h_dec;
   logic [X_W-1:0]          w_dec;
   logic [DC_W-1:0]         nw_dec;

   logic [NC_W-1:0]         ncols;
   logic [CW_W-1:0]         col_words_d;
   logic [NEED_W-1:0]       need_d;
   logic                    beat, dc_end, y_end, x_end, col_end, final_beat, x_rem_last;
   logic [B_BUF_ADDR-1:0]   col_base_d, addr_d;
   logic [XR_W-1:0]         x_rem_d;

   ftm_shape_decode #(
      .B_SHAPE     (B_SHAPE),
      .N_CONV_UNIT (N_CONV_UNIT)
   ) u_decode (
      .shape_i    (shape_q),
      .h_o        (h_dec),
      .w_o        (w_dec),
      .n_wrap_c_o (nw_dec)
   );

   // Bank footprint kept at full width so oversize shapes are caught, not wrapped.
   assign ncols       = (NC_W'(w_dec) + NC_W'(N_BUF_X - 1)) / NC_W'(N_BUF_X);
   assign col_words_d = CW_W'(nw_dec) * CW_W'(h_dec);
   assign need_d      = NEED_W'(col_words_d) * NEED_W'(ncols);

   assign beat       = s_axis_tvalid && (state_q == ST_STREAM);
   assign dc_end     = (dc_q == DC_W'(nw_dec - DC_W'(1)));
   assign y_end      = (y_q == Y_W'(h_dec - Y_W'(1)));
   assign x_end      = (x_q == X_W'(w_dec - X_W'(1)));
   assign col_end    = dc_end && y_end;
   assign final_beat = col_end && x_end;
   assign x_rem_last = (x_rem_q == XR_W'(N_BUF_X - 1));

   // After the last bank of a column group, move on to the next group of columns.
   assign col_base_d = x_rem_last ? col_base_q + col_words_q : col_base_q;
   assign x_rem_d    = x_rem_last ? '0 : x_rem_q + XR_W'(1);
   assign addr_d     = col_end ? col_base_d : addr_q + B_BUF_ADDR'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         shape_q     <= '0;
         col_words_q <= '0;
         dc_q        <= '0;
         y_q         <= '0;
         x_q         <= '0;
         x_rem_q     <= '0;
         addr_q      <= '0;
         col_base_q  <= '0;
         wr_en_q     <= '0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         shape_err_q <= 1'b0;
         last_err_q  <= 1'b0;
         tog_q       <= 1'b0;
      end else begin
         wr_en_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  shape_q     <= ftm_shape;
                  shape_err_q <= 1'b0;
                  last_err_q  <= 1'b0;
                  state_q     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (nw_dec == '0 || h_dec == '0 || w_dec == '0) begin
                  tog_q   <= ~tog_q;
                  state_q <= ST_IDLE;
               end else if (need_d > DEPTH) begin
                  shape_err_q <= 1'b1;
                  tog_q       <= ~tog_q;
                  state_q     <= ST_IDLE;
               end else begin
                  col_words_q <= col_words_d[B_BUF_ADDR-1:0];
                  dc_q        <= '0;
                  y_q         <= '0;
                  x_q         <= '0;
                  x_rem_q     <= '0;
                  addr_q      <= '0;
                  col_base_q  <= '0;
                  state_q     <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (beat) begin
                  wr_en_q   <= N_BUF_X'(1) << x_rem_q;
                  wr_addr_q <= addr_q;
                  wr_data_q <= s_axis_tdata;
                  if (s_axis_tlast != final_beat) last_err_q <= 1'b1;
                  if (final_beat) begin
                     tog_q   <= ~tog_q;
                     state_q <= ST_IDLE;
                  end else begin
                     addr_q <= addr_d;
                     if (col_end) begin
                        dc_q       <= '0;
                        y_q        <= '0;
                        x_q        <= x_q + X_W'(1);
                        x_rem_q    <= x_rem_d;
                        col_base_q <= col_base_d;
                     end else if (dc_end) begin
                        dc_q <= '0;
                        y_q  <= y_q + Y_W'(1);
                     end else begin
                        dc_q <= dc_q + DC_W'(1);
                     end
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign s_axis_tready = (state_q == ST_STREAM);
   assign busy          = (state_q != ST_IDLE);
   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign shape_err     = shape_err_q;
   assign last_err      = last_err_q;
   assign tog           = tog_q;

endmodule

// File: tb/tb_ftm_buffer_writer.sv
// Directed bench for ftm_buffer_writer: write placement, gaps, shape errors,
// tlast errors and asynchronous reset mid-map.
module tb_ftm_buffer_writer;

   localparam int N_BUF_X    = 10;
   localparam int B_BUF_ADDR = 9;
   localparam int DATA_WIDTH = 64;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [31:0]           ftm_shape;
   logic                  start;
   logic [DATA_WIDTH-1:0] s_axis_tdata;
   logic                  s_axis_tvalid;
   logic                  s_axis_tlast;
   logic                  s_axis_tready;
   logic [N_BUF_X-1:0]    wr_en;
   logic [B_BUF_ADDR-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  busy, shape_err, last_err, tog;

   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_tog = 1'b0;

   ftm_buffer_writer dut (
      .clk           (clk),
      .rstn          (rstn),
      .ftm_shape     (ftm_shape),
      .start         (start),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .busy          (busy),
      .shape_err     (shape_err),
      .last_err      (last_err),
      .tog           (tog)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_tready"}, s_axis_tready, 0);
      check({tag, "_shape_err"}, shape_err, 0);
      check({tag, "_last_err"}, last_err, 0);
      check({tag, "_tog"}, tog, 0);
   endtask

   task automatic start_map(input int c, input int h, input int w);
      ftm_shape = (32'(c) << 20) | (32'(h) << 10) | 32'(w);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("setup_busy", busy, 1);
      check("setup_tready", s_axis_tready, 0);
   endtask

   // Streams beats and checks each write against the bank/address formula.
   task automatic stream(input int c, input int h, input int w, input int gap,
                         input int tlast_b, input int stop_after, input logic exp_le);
      int nw, total, dc, y, x, streak;
      logic v;
      logic [9:0]  exp_en;
      logic [63:0] exp_d;
      nw    = c >> 5;
      total = nw * h * w;
      @(posedge clk); #1;
      check("stream_tready", s_axis_tready, 1);
      for (int b = 0; b < total && b < stop_after; b++) begin
         dc     = b % nw;
         y      = (b / nw) % h;
         x      = b / (nw * h);
         exp_en = 10'd1 << (x % N_BUF_X);
         exp_d  = {32'hDA7A_0000 + 32'(b), ~32'(b)};
         v      = 1'b0;
         streak = 0;
         while (!v) begin
            v = (gap == 0 || streak >= 8) ? 1'b1 : (int'($urandom_range(99)) >= gap);
            s_axis_tvalid = v;
            s_axis_tdata  = exp_d;
            s_axis_tlast  = v && (b == tlast_b);
            @(posedge clk); #1;
            if (v) begin
               check("wr_en", wr_en, exp_en);
               check("wr_addr", wr_addr, nw * (y + h * (x / N_BUF_X)) + dc);
               check("wr_data", wr_data, exp_d);
               if (b == total - 1) begin
                  exp_tog = ~exp_tog;
                  check("final_tog", tog, exp_tog);
                  check("final_busy", busy, 0);
                  check("final_tready", s_axis_tready, 0);
                  check("final_last_err", last_err, exp_le);
                  check("final_shape_err", shape_err, 0);
               end else begin
                  check("mid_tog", tog, exp_tog);
                  check("mid_tready", s_axis_tready, 1);
               end
            end else begin
               check("gap_wr_en", wr_en, 0);
               streak++;
            end
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   initial begin
      rstn          = 1'b0;
      ftm_shape     = '0;
      start         = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Full 72-beat map, no gaps.
      start_map(64, 3, 12);
      stream(64, 3, 12, 0, 71, 1000, 1'b0);

      // Same map with random idle cycles.
      start_map(64, 3, 12);
      stream(64, 3, 12, 30, 71, 1000, 1'b0);

      // Single column.
      start_map(32, 4, 1);
      stream(32, 4, 1, 0, 3, 1000, 1'b0);

      // Oversized map: 600 words needed, 512 available.
      start_map(32, 300, 11);
      @(posedge clk); #1;
      exp_tog = ~exp_tog;
      check("ovf_tog", tog, exp_tog);
      check("ovf_shape_err", shape_err, 1);
      check("ovf_busy", busy, 0);
      check("ovf_tready", s_axis_tready, 0);
      check("ovf_wr_en", wr_en, 0);
      @(posedge clk); #1;
      check("ovf_wr_en2", wr_en, 0);
      check("ovf_sticky", shape_err, 1);

      // Zero width: completes without writes, and the start clears shape_err.
      start_map(64, 3, 0);
      @(posedge clk); #1;
      exp_tog = ~exp_tog;
      check("w0_tog", tog, exp_tog);
      check("w0_wr_en", wr_en, 0);
      check("w0_busy", busy, 0);
      check("w0_shape_err", shape_err, 0);

      // Early tlast on beat 5: error flagged, all writes still made.
      start_map(64, 3, 12);
      stream(64, 3, 12, 0, 4, 1000, 1'b1);
      check("le_sticky", last_err, 1);
      start_map(64, 3, 0);
      check("le_cleared", last_err, 0);
      @(posedge clk); #1;
      exp_tog = ~exp_tog;
      check("le_w0_tog", tog, exp_tog);

      // Asynchronous reset after 20 beats, then a clean map.
      start_map(64, 3, 12);
      stream(64, 3, 12, 0, 71, 20, 1'b0);
      #2 rstn = 1'b0;
      #1;
      check_all_zero("async_rst");
      exp_tog = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      start_map(32, 4, 1);
      stream(32, 4, 1, 0, 3, 1000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
